// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite master: response codes, FSM encoding
// and the saturating latency-counter helper.
package axi_lite_pkg;

  localparam int LAT_WIDTH = 16;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] EXOKAY = 2'b01;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    WR_ADDR_DATA = 3'd1,
    WR_RESP      = 3'd2,
    RD_ADDR      = 3'd3,
    RD_DATA      = 3'd4,
    RSP          = 3'd5
  } state_t;

  function automatic logic [LAT_WIDTH-1:0] lat_inc(input logic [LAT_WIDTH-1:0] v);
    return (v == {LAT_WIDTH{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/axi_lite_master.sv
// AXI4-Lite single-outstanding master: turns one command into one AXI read or
// write transaction and reports data, response and cycle latency back.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    M_AXI_ACLK,
  input  logic                    M_AXI_ARESET,

  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,

  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]              rsp_resp,
  output logic [LAT_WIDTH-1:0]    rsp_latency,

  output logic [ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [2:0]              M_AXI_AWPROT,
  output logic                    M_AXI_AWVALID,
  input  logic                    M_AXI_AWREADY,

  output logic [DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                    M_AXI_WVALID,
  input  logic                    M_AXI_WREADY,

  input  logic [1:0]              M_AXI_BRESP,
  input  logic                    M_AXI_BVALID,
  output logic                    M_AXI_BREADY,

  output logic [ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [2:0]              M_AXI_ARPROT,
  output logic                    M_AXI_ARVALID,
  input  logic                    M_AXI_ARREADY,

  input  logic [DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]              M_AXI_RRESP,
  input  logic                    M_AXI_RVALID,
  output logic                    M_AXI_RREADY
);

  state_t                  state, state_nxt;
  logic                    run_q;
  logic                    aw_done, w_done;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] wstrb_q;
  logic [LAT_WIDTH-1:0]    lat;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) state <= IDLE;
    else              state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:         if (cmd_valid && run_q) state_nxt = cmd_write ? WR_ADDR_DATA : RD_ADDR;
      WR_ADDR_DATA: if ((aw_done || M_AXI_AWREADY) && (w_done || M_AXI_WREADY)) state_nxt = WR_RESP;
      WR_RESP:      if (M_AXI_BVALID) state_nxt = RSP;
      RD_ADDR:      if (M_AXI_ARREADY) state_nxt = RD_DATA;
      RD_DATA:      if (M_AXI_RVALID) state_nxt = RSP;
      RSP:          if (rsp_ready) state_nxt = IDLE;
      default:      state_nxt = IDLE;
    endcase
  end

  // Handshake outputs are pure decodes of registered state, so no input reaches them combinationally.
  always_comb begin
    cmd_ready     = 1'b0;
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    rsp_valid     = 1'b0;
    unique case (state)
      IDLE:         cmd_ready = run_q;
      WR_ADDR_DATA: begin
        M_AXI_AWVALID = !aw_done;
        M_AXI_WVALID  = !w_done;
      end
      WR_RESP:      M_AXI_BREADY  = 1'b1;
      RD_ADDR:      M_AXI_ARVALID = 1'b1;
      RD_DATA:      M_AXI_RREADY  = 1'b1;
      RSP:          rsp_valid     = 1'b1;
      default:      ;
    endcase
  end

  assign M_AXI_AWADDR = addr_q;
  assign M_AXI_ARADDR = addr_q;
  assign M_AXI_AWPROT = 3'b000;
  assign M_AXI_ARPROT = 3'b000;
  assign M_AXI_WDATA  = wdata_q;
  assign M_AXI_WSTRB  = wstrb_q;

  always_ff @(posedge M_AXI_ACLK) begin
    if (M_AXI_ARESET) begin
      run_q       <= 1'b0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      lat         <= '0;
      rsp_rdata   <= '0;
      rsp_resp    <= OKAY;
      rsp_latency <= '0;
    end else begin
      run_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (cmd_valid && run_q) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            lat     <= '0;
          end
        end
        WR_ADDR_DATA: begin
          lat <= lat_inc(lat);
          if (M_AXI_AWVALID && M_AXI_AWREADY) aw_done <= 1'b1;
          if (M_AXI_WVALID && M_AXI_WREADY)   w_done  <= 1'b1;
        end
        WR_RESP: begin
          lat <= lat_inc(lat);
          if (M_AXI_BVALID) begin
            rsp_rdata   <= '0;
            rsp_resp    <= M_AXI_BRESP;
            rsp_latency <= lat_inc(lat);
          end
        end
        RD_ADDR: lat <= lat_inc(lat);
        RD_DATA: begin
          lat <= lat_inc(lat);
          if (M_AXI_RVALID) begin
            rsp_rdata   <= M_AXI_RDATA;
            rsp_resp    <= M_AXI_RRESP;
            rsp_latency <= lat_inc(lat);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_master.sv
// Directed bench for axi_lite_master: table of transactions against a
// delay-programmable slave model, plus reset and latency-saturation sequences.
module tb_axi_lite_master;
  import axi_lite_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_resp;
  logic [15:0] rsp_latency;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_lite_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESET(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_latency(rsp_latency),
    .M_AXI_AWADDR(awaddr), .M_AXI_AWPROT(awprot), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WVALID(wvalid), .M_AXI_WREADY(wready),
    .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARADDR(araddr), .M_AXI_ARPROT(arprot), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct {
    bit          write;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          aw_dly;
    int          w_dly;
    int          ar_dly;
    int          resp_dly;
    logic [1:0]  resp;
    logic [31:0] rdata;
    int          hold;
    logic [31:0] exp_rdata;
    logic [15:0] exp_lat;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] sat16(input int v);
    return (v > 65535) ? 16'hFFFF : v[15:0];
  endfunction

  task automatic run_vec(input vec_t v);
    int busy = 0, cyc = 0;
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int n_aw = 0, n_w = 0, n_b = 0;
    bit aw_ok, w_ok, ar_ok = 0, fin = 0;
    bit prev_aw = 0, prev_w = 0, prev_ar = 0;
    logic [1:0]  s_resp;
    logic [31:0] s_rdata;
    logic [15:0] s_lat;

    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_wstrb = v.wstrb;
    @(negedge clk);
    cmd_valid = 0;
    if (v.write) begin
      chk("aw_w_first_cycle", {awvalid, wvalid}, 2'b11);
      chk("awaddr", awaddr, v.addr);
      chk("wdata", wdata, v.wdata);
      chk("wstrb", wstrb, v.wstrb);
      chk("awprot", awprot, 0);
    end else begin
      chk("arvalid_first_cycle", arvalid, 1);
      chk("araddr", araddr, v.addr);
      chk("arprot", arprot, 0);
    end

    while (!fin && cyc < 80000) begin
      cyc++;
      if (awvalid || wvalid || bready || arvalid || rready) busy++;
      chk("cmd_ready_busy", cmd_ready, 0);
      if (prev_aw) chk("awvalid_hold", {awvalid, awaddr}, {1'b1, v.addr});
      if (prev_w)  chk("wvalid_hold", {wvalid, wdata}, {1'b1, v.wdata});
      if (prev_ar) chk("arvalid_hold", {arvalid, araddr}, {1'b1, v.addr});
      aw_ok = (n_aw > 0);
      w_ok  = (n_w > 0);

      awready = awvalid && (aw_cnt >= v.aw_dly);
      wready  = wvalid && (w_cnt >= v.w_dly);
      arready = arvalid && (ar_cnt >= v.ar_dly);
      if (awvalid) aw_cnt++;
      if (wvalid)  w_cnt++;
      if (arvalid) ar_cnt++;
      if (awvalid && awready) n_aw++;
      if (wvalid && wready)   n_w++;
      prev_aw = awvalid && !awready;
      prev_w  = wvalid && !wready;
      prev_ar = arvalid && !arready;

      if (v.write && aw_ok && w_ok) begin
        bvalid = (b_cnt >= v.resp_dly);
        bresp  = v.resp;
        b_cnt++;
        if (bvalid && bready) begin n_b++; fin = 1; end
      end
      if (!v.write && ar_ok) begin
        rvalid = (r_cnt >= v.resp_dly);
        rresp  = v.resp;
        rdata  = v.rdata;
        r_cnt++;
        if (rvalid && rready) fin = 1;
      end
      if (arvalid && arready) ar_ok = 1;
      @(negedge clk);
    end
    awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;

    if (!fin) chk("txn_timeout", 0, 1);
    if (v.write) begin
      chk("aw_handshakes", n_aw, 1);
      chk("w_handshakes", n_w, 1);
      chk("b_handshakes", n_b, 1);
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_resp", rsp_resp, v.resp);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_latency_table", rsp_latency, v.exp_lat);
    chk("rsp_latency_counted", rsp_latency, sat16(busy));
    chk("axi_quiet_in_rsp", {awvalid, wvalid, bready, arvalid, rready}, 0);

    s_resp = rsp_resp; s_rdata = rsp_rdata; s_lat = rsp_latency;
    rsp_ready = 0;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      chk("rsp_hold_stable", {rsp_valid, rsp_resp, rsp_rdata[28:0]}, {1'b1, s_resp, s_rdata[28:0]});
      chk("rsp_hold_fields", {s_rdata[31:29], s_lat}, {rsp_rdata[31:29], rsp_latency});
      chk("cmd_ready_in_rsp", cmd_ready, 0);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("rsp_valid_after_hs", rsp_valid, 0);
    chk("cmd_ready_after_hs", cmd_ready, 1);
  endtask

  initial begin
    //            wr   addr           wdata          strb  aw w  ar rsp   resp    rdata          hold exp_rdata      exp_lat
    vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 0, 0, 0, 0,     OKAY,   32'h0,         0,   32'h0,         16'd2};
    vecs[1] = '{1'b1, 32'h0000_0103, 32'hA5A5_5A5A, 4'h3, 3, 0, 0, 2,     SLVERR, 32'h0,         2,   32'h0,         16'd7};
    vecs[2] = '{1'b0, 32'h0000_0008, 32'h0,         4'h0, 0, 0, 5, 0,     SLVERR, 32'h1234_5678, 10,  32'h1234_5678, 16'd7};
    vecs[3] = '{1'b0, 32'h0000_0010, 32'h0,         4'h0, 0, 0, 0, 4,     DECERR, 32'hCAFE_F00D, 1,   32'hCAFE_F00D, 16'd6};
    vecs[4] = '{1'b1, 32'h0000_0020, 32'h0000_0001, 4'h1, 0, 2, 0, 0,     EXOKAY, 32'h0,         0,   32'h0,         16'd4};
    vecs[5] = '{1'b0, 32'hFFFF_FFFE, 32'h0,         4'h0, 0, 0, 1, 1,     OKAY,   32'h0000_0000, 3,   32'h0000_0000, 16'd4};
    vecs[6] = '{1'b0, 32'h0000_0040, 32'h0,         4'h0, 0, 0, 0, 70000, OKAY,   32'h0BAD_F00D, 0,   32'h0BAD_F00D, 16'hFFFF};

    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0; cmd_wstrb = 0;
    rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 32'h7777_7777; rresp = 0;
    repeat (3) @(negedge clk);
    chk("reset_handshakes", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    chk("reset_rsp_fields", {rsp_resp, rsp_latency}, 0);
    chk("reset_rsp_rdata", rsp_rdata, 0);
    rst = 0;
    @(negedge clk);
    chk("cmd_ready_after_reset", cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(vecs[i]);

    // Reset while WR_RESP is waiting and BVALID arrives in the same cycle.
    cmd_valid = 1; cmd_write = 1; cmd_addr = 32'h50; cmd_wdata = 32'h1111_2222; cmd_wstrb = 4'hF;
    @(negedge clk);
    cmd_valid = 0; awready = 1; wready = 1;
    @(negedge clk);
    awready = 0; wready = 0;
    chk("bready_in_wr_resp", {bready, awvalid, wvalid}, 3'b100);
    @(negedge clk);
    bvalid = 1; bresp = OKAY; rst = 1;
    @(negedge clk);
    bvalid = 0;
    chk("reset_abandon_outputs", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid}, 0);
    @(negedge clk);
    chk("reset_abandon_no_rsp", rsp_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("cmd_ready_after_reset2", cmd_ready, 1);
    chk("no_rsp_after_reset2", rsp_valid, 0);
    run_vec(vecs[3]);

    run_vec(vecs[6]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_lite_master.md
AXI_LITE_MASTER -- requirements
Module: axi_lite_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, AXI address width.
REQ-002 Parameter DATA_WIDTH, default 32, AXI data width; only 32 is supported.
REQ-003 M_AXI_ACLK  in  1  sole clock; every register samples on its rising edge.
REQ-004 M_AXI_ARESET  in  1  reset, synchronous, active-high.
REQ-005 cmd_valid/cmd_ready  in/out  1/1  command handshake.
REQ-006 cmd_write  in  1  1 = write, 0 = read.
REQ-007 cmd_addr  in  ADDR_WIDTH  byte address.
REQ-008 cmd_wdata/cmd_wstrb  in  32/4  write data and byte strobes.
REQ-009 rsp_valid/rsp_ready  out/in  1/1  response handshake.
REQ-010 rsp_rdata/rsp_resp/rsp_latency  out  32/2/16  read data, AXI response, cycles from address issue to B/R handshake.
REQ-011 M_AXI_AW{ADDR,PROT,VALID,READY}, W{DATA,STRB,VALID,READY}, B{RESP,VALID,READY}, AR{ADDR,PROT,VALID,READY}, R{DATA,RESP,VALID,READY}  AXI4-Lite master side, standard widths and directions.

Function
REQ-012 FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, RSP.
REQ-013 cmd_ready = 1 only in IDLE; a command is accepted when cmd_valid & cmd_ready, and its fields are registered in that cycle.
REQ-014 Accepted write -> WR_ADDR_DATA; AWVALID and WVALID both assert the next cycle (latency 1).
REQ-015 In WR_ADDR_DATA, AW and W complete independently: each VALID drops the cycle after its own handshake; both may complete in the same cycle, in either order, or in different cycles.
REQ-016 After both aw_done and w_done -> WR_RESP; BREADY = 1 only in WR_RESP; a BVALID seen outside WR_RESP is ignored.
REQ-017 Accepted read -> RD_ADDR; ARVALID asserts the next cycle and holds until ARREADY; then -> RD_DATA; RREADY = 1 only in RD_DATA.
REQ-018 On B or R handshake -> RSP; the cycle after the handshake, rsp_valid = 1 with rsp_resp = BRESP/RRESP; rsp_rdata = RDATA for reads and 0 for writes.
REQ-019 RSP holds rsp_valid and all rsp_* fields stable until rsp_ready; the handshake cycle returns to IDLE, and cmd_ready = 1 on the following cycle.
REQ-020 No VALID is ever deasserted before its handshake; no AXI output changes while VALID is high and READY is low.
REQ-021 AWPROT = ARPROT = 3'b000; AWADDR/ARADDR = registered cmd_addr, unaligned bits passed through unmodified.
REQ-022 Latency counter clears when the address phase begins, increments each cycle in WR_ADDR_DATA/WR_RESP/RD_ADDR/RD_DATA, and saturates at 16'hFFFF without wrapping; its value is captured into rsp_latency at the B/R handshake.
REQ-023 rsp_resp SLVERR/DECERR is passed through unchanged; the block performs no retry.
REQ-024 All AXI and rsp outputs are driven from registers; no combinational path from any input to any output.

Reset
REQ-025 While M_AXI_ARESET = 1: state = IDLE; all VALID/READY outputs = 0; cmd_ready = 0; rsp_* = 0; latency counter = 0.
REQ-026 cmd_ready = 1 on the first cycle after reset deasserts.
REQ-027 Reset mid-transaction abandons the transaction at once; no response is produced for it.

Structure
REQ-028 Shared package axi_lite_pkg holds the response constants (OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11), the FSM state encoding, and LAT_WIDTH = 16.
REQ-029 Single module with no sub-module; it is intended for connection to axi_lite_slave in loopback benches.

Verification
REQ-030 Write addr 0x0000_0004, data 0xDEADBEEF, strb 0xF; slave with AWREADY/WREADY = 1 and BRESP = OKAY -> AWVALID and WVALID assert together 1 cycle after accept; rsp_resp = 00, rsp_rdata = 0.
REQ-031 Slave raises WREADY 3 cycles before AWREADY -> WVALID drops after its own handshake, AWVALID stays high until AWREADY; exactly one B handshake occurs.
REQ-032 Read addr 0x0000_0008, slave returns RDATA = 0x12345678 with RRESP = SLVERR after a 5-cycle ARREADY stall -> rsp_rdata = 0x12345678, rsp_resp = 10, rsp_latency matches the bench-counted value.
REQ-033 rsp_ready held low for 10 cycles -> rsp_* stable throughout, cmd_ready = 0 throughout; cmd_ready = 1 the cycle after the rsp handshake.
REQ-034 Assert reset while in WR_RESP with BVALID pending -> all VALID/READY = 0 the next cycle, no rsp_valid; a subsequent read completes normally.
REQ-035 Slave withholds RVALID for 70000 cycles -> rsp_latency = 16'hFFFF with no wrap; the transaction then completes.
